// File: rtl/uart_tx_engine.sv
// uart_tx_engine: buffered 8N1 UART transmitter.
// Byte FIFO feeding a start/data/stop serializer with a programmable divisor.
module uart_tx_engine #(
    parameter int FIFO_DEPTH      = 8,
    parameter int DEFAULT_DIVISOR = 434
) (
    input  logic                          clock,
    input  logic                          init_flag,
    input  logic                          UART_ENB,
    input  logic [2:0]                    instruction,
    input  logic [31:0]                   write_value,
    output logic                          ready_to_send,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] CMD_SEND = 3'b001;
    localparam logic [2:0] CMD_BAUD = 3'b010;
    localparam logic [2:0] CMD_CLR  = 3'b011;

    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [31:0]   DIV_RST  = 32'(DEFAULT_DIVISOR);
    localparam logic [31:0]   DIV_MIN  = 32'd2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [31:0]     div_reg;
    logic [31:0]     active_div;
    logic [31:0]     baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;

    logic            is_send;
    logic            is_baud;
    logic            is_clr;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            bit_done;
    logic            frame_end;
    logic [CW-1:0]   count_nxt;

    // Command decode and FIFO push/pop qualification (fullness before pop).
    always_comb begin
        is_send    = UART_ENB && (instruction == CMD_SEND);
        is_baud    = UART_ENB && (instruction == CMD_BAUD);
        is_clr     = UART_ENB && (instruction == CMD_CLR);
        fifo_full  = (fifo_count == FULL_CNT);
        fifo_empty = (fifo_count == '0);
        bit_done   = (baud_cnt == active_div - 32'd1);
        frame_end  = (state == STOP) && bit_done;
        push       = is_send && !fifo_full;
        pop        = !fifo_empty && ((state == IDLE) || frame_end);
    end

    // Occupancy after this edge's push and pop.
    always_comb begin
        count_nxt = fifo_count;
        unique case (1'b1)
            (push && !pop): count_nxt = fifo_count + CW'(1);
            (pop && !push): count_nxt = fifo_count - CW'(1);
            default:        count_nxt = fifo_count;
        endcase
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= write_value[7:0];
        end
    end

    // FIFO pointers, occupancy and the registered not-full flag.
    always_ff @(posedge clock) begin
        if (init_flag) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            ready_to_send <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count    <= count_nxt;
            ready_to_send <= (count_nxt != FULL_CNT);
        end
    end

    // Baud divisor register and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (init_flag) begin
            div_reg  <= DIV_RST;
            overflow <= 1'b0;
        end else begin
            if (is_baud) begin
                div_reg <= (write_value < DIV_MIN) ? DIV_MIN : write_value;
            end
            if (is_send && fifo_full) begin
                overflow <= 1'b1;
            end else if (is_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Serializer: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge clock) begin
        if (init_flag) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            active_div <= DIV_RST;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (pop) begin
                        shift_reg  <= mem[rd_ptr];
                        active_div <= div_reg;
                        baud_cnt   <= '0;
                        bit_cnt    <= '0;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 32'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 32'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_reg  <= mem[rd_ptr];
                            active_div <= div_reg;
                            bit_cnt    <= '0;
                            tx         <= 1'b0;
                            state      <= START;
                        end else begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: scoreboard bench for uart_tx_engine.
// Stimulus queues expected bytes; a line monitor decodes and compares frames.
module tb_uart_tx_engine;

    localparam logic [2:0] CMD_SEND = 3'b001;
    localparam logic [2:0] CMD_BAUD = 3'b010;
    localparam logic [2:0] CMD_CLR  = 3'b011;

    logic        clock;
    logic        init_flag;
    logic        UART_ENB;
    logic [2:0]  instruction;
    logic [31:0] write_value;
    logic        ready_to_send;
    logic        tx;
    logic        busy;
    logic [3:0]  fifo_count;
    logic        overflow;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          model_div;
    bit          mon_en = 0;
    logic [7:0]  exp_q[$];

    uart_tx_engine #(
        .FIFO_DEPTH(8),
        .DEFAULT_DIVISOR(5)
    ) dut (
        .clock(clock),
        .init_flag(init_flag),
        .UART_ENB(UART_ENB),
        .instruction(instruction),
        .write_value(write_value),
        .ready_to_send(ready_to_send),
        .tx(tx),
        .busy(busy),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] ins, input logic [31:0] val);
        UART_ENB    = 1'b1;
        instruction = ins;
        write_value = val;
        @(posedge clock);
        #1;
        UART_ENB    = 1'b0;
        instruction = 3'b000;
        write_value = '0;
    endtask

    task automatic send(input logic [7:0] b, input bit expect_ok);
        if (expect_ok) exp_q.push_back(b);
        issue(CMD_SEND, {24'd0, b});
    endtask

    task automatic set_baud(input logic [31:0] v);
        issue(CMD_BAUD, v);
        model_div = (v < 32'd2) ? 2 : int'(v);
    endtask

    task automatic wait_done(input int t0, input int exp_len,
                             input string name);
        int n;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while ((busy !== 1'b0 || fifo_count !== 4'd0) && n < 3000);
        check(name, cyc - t0, exp_len);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Line monitor: pops one expected byte per start bit and checks each clock.
    initial begin
        logic [7:0] b;
        int d;
        int bad;
        bit aborted;
        bit just_done;
        just_done = 0;
        forever begin
            @(negedge clock);
            if (mon_en && !init_flag) begin
                if (just_done) begin
                    if (exp_q.size() != 0) check("gapless_start", tx, 0);
                    else check("busy_fall", busy, 0);
                    just_done = 0;
                end
                if (tx === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", tx, 1);
                        while (tx !== 1'b1 && !init_flag) @(negedge clock);
                    end else begin
                        b = exp_q.pop_front();
                        d = model_div;
                        bad = 0;
                        aborted = 0;
                        for (int k = 0; k < 10 * d; k++) begin
                            if (k > 0) @(negedge clock);
                            if (init_flag) begin
                                aborted = 1;
                                break;
                            end
                            if (tx !== frame_bit(b, k / d) || busy !== 1'b1)
                                bad++;
                        end
                        if (!aborted) begin
                            check($sformatf("frame_%02h_div%0d", b, d), bad, 0);
                            just_done = 1;
                        end
                    end
                end
            end else begin
                just_done = 0;
            end
        end
    end

    // Directed stimulus.
    initial begin
        int t0;
        int lows;
        init_flag   = 1'b1;
        UART_ENB    = 1'b0;
        instruction = 3'b000;
        write_value = '0;
        model_div   = 5;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", ready_to_send, 1);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        init_flag = 1'b0;
        mon_en    = 1;
        repeat (2) @(posedge clock);
        #1;

        // Default divisor after reset.
        send(8'h5A, 1);
        t0 = cyc;
        wait_done(t0, 51, "len_default_div");

        // 0x55 at D=4 with first-frame latency.
        set_baud(32'd4);
        send(8'h55, 1);
        t0 = cyc;
        check("e0_count", fifo_count, 1);
        check("e0_busy", busy, 0);
        @(posedge clock);
        #1;
        check("e1_tx", tx, 0);
        check("e1_busy", busy, 1);
        check("e1_count", fifo_count, 0);
        wait_done(t0, 41, "len_55_d4");

        // Clamp to 2.
        set_baud(32'd0);
        send(8'hA3, 1);
        t0 = cyc;
        wait_done(t0, 21, "len_a3_d2");

        // Burst of 9 plus an overflowing 10th.
        set_baud(32'd3);
        for (int i = 0; i < 9; i++) begin
            send(8'(8'h10 + i), 1);
            if (i == 0) t0 = cyc;
        end
        check("burst_count", fifo_count, 8);
        check("burst_ready", ready_to_send, 0);
        check("burst_ovf0", overflow, 0);
        send(8'h99, 0);
        check("drop_ovf", overflow, 1);
        check("drop_count", fifo_count, 8);
        issue(CMD_CLR, 32'd0);
        check("clr_ovf", overflow, 0);
        wait_done(t0, 271, "len_burst");

        // Divisor change mid-frame affects only the next frame.
        set_baud(32'd4);
        send(8'h3C, 1);
        t0 = cyc;
        send(8'hC3, 1);
        repeat (10) @(posedge clock);
        #1;
        set_baud(32'd8);
        wait_done(t0, 121, "len_mid_baud");

        // Push and pop on the same edge at a stop-bit end.
        set_baud(32'd3);
        send(8'hF0, 1);
        t0 = cyc;
        send(8'h0F, 1);
        send(8'hCC, 1);
        send(8'h33, 1);
        check("pp_count_pre", fifo_count, 3);
        repeat (27) @(posedge clock);
        #1;
        send(8'hE7, 1);
        check("pp_count", fifo_count, 3);
        check("pp_tx", tx, 0);
        check("pp_busy", busy, 1);
        wait_done(t0, 151, "len_pushpop");

        // Reset during data bit 3 with two bytes queued.
        set_baud(32'd4);
        send(8'h11, 1);
        send(8'h22, 1);
        send(8'h33, 1);
        check("mr_count_pre", fifo_count, 2);
        repeat (16) @(posedge clock);
        #1;
        init_flag = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1;
        check("mr_tx", tx, 1);
        check("mr_busy", busy, 0);
        check("mr_count", fifo_count, 0);
        check("mr_ready", ready_to_send, 1);
        init_flag = 1'b0;
        model_div = 5;
        lows = 0;
        repeat (100) begin
            @(posedge clock);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("mr_silent", lows, 0);

        // Divisor returned to its reset value.
        send(8'h81, 1);
        t0 = cyc;
        wait_done(t0, 51, "len_after_rst");

        repeat (5) @(posedge clock);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
